// File: rtl/bitty_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// bitty_pkg
// Shared definitions for the Bitty control sequencer: instruction width,
// Rx field location, halt-format encoding and the FSM state enumeration.
// No ports.
// -----------------------------------------------------------------------------
package bitty_pkg;

  localparam int INSTR_W = 16;
  localparam int RX_MSB  = 15;
  localparam int RX_LSB  = 13;

  // Low two bits of an instruction select its format; 2'b11 means halt.
  localparam logic [1:0] FMT_HALT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_EXEC_S = 3'd3,
    ST_EXEC_C = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] ins);
    return ins[1:0] == FMT_HALT;
  endfunction

endpackage

// File: rtl/bitty_sequencer_if.sv
// -----------------------------------------------------------------------------
// bitty_sequencer_if
// Bundles the instruction-memory fetch handshake and the datapath enable
// interface seen by the sequencer.
//   imem_req/imem_addr     : fetch request and address (sequencer -> imem)
//   imem_valid/imem_data   : fetch response (imem -> sequencer)
//   instr, en_i/en_s/en_c  : instruction word and phase enables (-> datapath)
//   en_reg                 : one-hot register writeback enable (-> datapath)
//   dp_done                : datapath completion strobe (datapath -> sequencer)
// master = sequencer side, slave = memory/datapath side.
// -----------------------------------------------------------------------------
interface bitty_sequencer_if #(
  parameter int PC_W     = 8,
  parameter int NUM_REGS = 8
);
  import bitty_pkg::*;

  logic                imem_req;
  logic [PC_W-1:0]     imem_addr;
  logic                imem_valid;
  logic [INSTR_W-1:0]  imem_data;
  logic [INSTR_W-1:0]  instr;
  logic                en_i;
  logic                en_s;
  logic                en_c;
  logic [NUM_REGS-1:0] en_reg;
  logic                dp_done;

  modport master (
    output imem_req, imem_addr, instr, en_i, en_s, en_c, en_reg,
    input  imem_valid, imem_data, dp_done
  );

  modport slave (
    input  imem_req, imem_addr, instr, en_i, en_s, en_c, en_reg,
    output imem_valid, imem_data, dp_done
  );

endinterface

// File: rtl/bitty_sequencer_pc_counter.sv
// -----------------------------------------------------------------------------
// bitty_pc_counter
// Program counter (wraps modulo 2^PC_W) and retired-instruction counter
// (saturates at all-ones). Both advance together on inc.
//   clk, reset   : clock, asynchronous active-high reset
//   inc          : one instruction retired this cycle
//   pc           : current program counter
//   instr_count  : retired instruction count
// -----------------------------------------------------------------------------
module bitty_pc_counter #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] instr_count
);

  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      count_q <= '0;
    end else if (inc) begin
      pc_q <= pc_q + PC_W'(1);
      if (count_q != '1) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign pc          = pc_q;
  assign instr_count = count_q;

endmodule

// File: rtl/bitty_sequencer.sv
// -----------------------------------------------------------------------------
// bitty_sequencer
// Control FSM for the Bitty datapath: fetches an instruction over the imem
// handshake, then steps it through load, compute-S, compute-C and writeback.
// Tracks PC, retired count, halt status and a sticky protocol-error flag.
//   clk, reset    : clock, asynchronous active-high reset
//   run           : 1 = fetch/execute, 0 = stop at next instruction boundary
//   bus (master)  : imem handshake + datapath enables (bitty_sequencer_if)
//   busy          : FSM not in IDLE or HALT
//   halted        : halt instruction captured
//   err           : sticky, dp_done missing during EXEC_C
//   pc            : current program counter
//   instr_count   : retired instructions, saturating
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | stopped; wait for run
// FETCH   | imem_req high, wait for imem_valid, capture instruction
// LOAD    | en_i: datapath latches instr
// EXEC_S  | en_s: datapath loads S
// EXEC_C  | en_c: datapath loads C, dp_done expected
// WB      | en_reg one-hot on Rx, retire (pc+1, count+1), sample run
// HALT    | halt instruction seen; terminal until reset
// -----------------------------------------------------------------------------
module bitty_sequencer
  import bitty_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int NUM_REGS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  bitty_sequencer_if.master      bus,
  output logic                   busy,
  output logic                   halted,
  output logic                   err,
  output logic [PC_W-1:0]        pc,
  output logic [15:0]            instr_count
);

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_FETCH  = 3'(ST_FETCH);
  localparam logic [2:0] S_LOAD   = 3'(ST_LOAD);
  localparam logic [2:0] S_EXEC_S = 3'(ST_EXEC_S);
  localparam logic [2:0] S_EXEC_C = 3'(ST_EXEC_C);
  localparam logic [2:0] S_WB     = 3'(ST_WB);
  localparam logic [2:0] S_HALT   = 3'(ST_HALT);

  logic [2:0]          state_q;
  logic [2:0]          state_d;
  logic [INSTR_W-1:0]  instr_q;
  logic                err_q;
  logic                retire;
  logic [PC_W-1:0]     pc_w;
  logic [NUM_REGS-1:0] rx_onehot;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (bus.imem_valid) state_d = is_halt(bus.imem_data) ? S_HALT : S_LOAD;
      S_LOAD:   state_d = S_EXEC_S;
      S_EXEC_S: state_d = S_EXEC_C;
      S_EXEC_C: state_d = S_WB;
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // imem_valid is only meaningful while a fetch is outstanding.
      if (state_q == S_FETCH && bus.imem_valid) begin
        instr_q <= bus.imem_data;
      end
      // The FSM advances regardless; the missing strobe is only recorded.
      if (state_q == S_EXEC_C && !bus.dp_done) begin
        err_q <= 1'b1;
      end
    end
  end

  assign retire = (state_q == S_WB);

  bitty_pc_counter #(
    .PC_W  (PC_W),
    .CNT_W (16)
  ) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .inc         (retire),
    .pc          (pc_w),
    .instr_count (instr_count)
  );

  assign rx_onehot = NUM_REGS'(1) << instr_q[RX_MSB:RX_LSB];

  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc_w;
  assign bus.instr     = instr_q;
  assign bus.en_i      = (state_q == S_LOAD);
  assign bus.en_s      = (state_q == S_EXEC_S);
  assign bus.en_c      = (state_q == S_EXEC_C);
  assign bus.en_reg    = retire ? rx_onehot : '0;

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);
  assign err    = err_q;
  assign pc     = pc_w;

endmodule

// File: tb/tb_bitty_sequencer.sv
module tb_bitty_sequencer;
  import bitty_pkg::*;

  typedef struct packed {
    logic        req;
    logic [7:0]  addr;
    logic [15:0] instr;
    logic        en_i;
    logic        en_s;
    logic        en_c;
    logic [7:0]  en_reg;
    logic        busy;
    logic        halted;
    logic        err;
    logic [7:0]  pc;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    logic        run;
    logic        valid;
    logic [15:0] data;
    logic        dp;
    obs_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        valid_r = 1'b0;
  logic        dp_ok = 1'b1;
  logic [15:0] data_r = 16'h0;
  logic        busy, halted, err;
  logic [7:0]  pc;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  // Reference model state, advanced one instruction at a time.
  logic [7:0]  m_pc;
  logic [15:0] m_cnt;
  logic [15:0] m_instr;
  logic        m_err;
  bit          m_idle;

  bitty_sequencer_if #(.PC_W(8), .NUM_REGS(8)) bus ();

  assign bus.imem_valid = valid_r;
  assign bus.imem_data  = data_r;
  assign bus.dp_done    = bus.en_c & dp_ok;

  bitty_sequencer #(.PC_W(8), .NUM_REGS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .bus         (bus),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .pc          (pc),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample_obs();
    obs_t o;
    o.req = bus.imem_req;  o.addr = bus.imem_addr; o.instr = bus.instr;
    o.en_i = bus.en_i;     o.en_s = bus.en_s;      o.en_c = bus.en_c;
    o.en_reg = bus.en_reg; o.busy = busy;          o.halted = halted;
    o.err = err;           o.pc = pc;              o.cnt = instr_count;
    return o;
  endfunction

  function automatic obs_t mk(logic req, logic [7:0] addr, logic [15:0] ins, logic i, logic s,
                              logic c, logic [7:0] rg, logic bsy, logic hlt, logic er,
                              logic [7:0] p, logic [15:0] n);
    obs_t o;
    o.req = req; o.addr = addr; o.instr = ins; o.en_i = i; o.en_s = s; o.en_c = c;
    o.en_reg = rg; o.busy = bsy; o.halted = hlt; o.err = er; o.pc = p; o.cnt = n;
    return o;
  endfunction

  // Expected outputs with nothing active, from the model's architectural state.
  function automatic obs_t base();
    return mk(1'b0, m_pc, m_instr, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, m_err, m_pc, m_cnt);
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] junk();
    return 16'($urandom);
  endfunction

  task automatic chk(input obs_t e, input string name);
    obs_t a;
    a = sample_obs();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  task automatic drive_step(input logic r, input logic v, input logic [15:0] d);
    run = r; valid_r = v; data_r = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_cnt = 16'h0; m_instr = 16'h0; m_err = 1'b0; m_idle = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; valid_r = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One instruction from the spec's phase sequence: `waits` idle fetch cycles,
  // then LOAD, S, C, WB; halt-format words end in HALT forever.
  task automatic run_instr(input logic [15:0] d, input int waits, input bit dp,
                           input bit run_after, input bit abort_c);
    obs_t e;
    if (m_idle) begin
      chk(base(), "idle_start");
      drive_step(1'b1, rb(), junk());
      m_idle = 1'b0;
    end
    for (int i = 0; i <= waits; i++) begin
      e = base(); e.req = 1'b1; e.busy = 1'b1;
      chk(e, "fetch");
      drive_step(rb(), (i == waits), (i == waits) ? d : junk());
    end
    m_instr = d;
    if (d[1:0] == 2'b11) begin
      for (int i = 0; i < 4; i++) begin
        e = base(); e.halted = 1'b1;
        chk(e, "halt");
        drive_step(rb(), rb(), junk());
      end
      return;
    end
    e = base(); e.en_i = 1'b1; e.busy = 1'b1;
    chk(e, "load");
    drive_step(rb(), rb(), junk());
    e = base(); e.en_s = 1'b1; e.busy = 1'b1;
    chk(e, "exec_s");
    drive_step(rb(), rb(), junk());
    dp_ok = dp;
    e = base(); e.en_c = 1'b1; e.busy = 1'b1;
    chk(e, "exec_c");
    if (abort_c) begin
      reset = 1'b1;
      #1;
      model_reset();
      chk(base(), "reset_in_c");
      @(negedge clk);
      chk(base(), "reset_hold");
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk(base(), "post_reset");
        drive_step(1'b0, rb(), junk());
      end
      return;
    end
    drive_step(rb(), rb(), junk());
    if (!dp) m_err = 1'b1;
    e = base(); e.en_reg = 8'h01 << d[15:13]; e.busy = 1'b1;
    chk(e, "wb");
    drive_step(run_after, rb(), junk());
    m_pc = m_pc + 8'h01;
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
    if (!run_after) begin
      chk(base(), "stop_idle");
      m_idle = 1'b1;
    end
  endtask

  vec_t tbl[7];

  initial begin
    logic [15:0] d;
    // Straight line: one zero-wait instruction 16'h2000 (Rx=1) at address 0.
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, mk(0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 16'h0)};
    tbl[1] = '{1'b1, 1'b1, 16'h2000, 1'b1, mk(1, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 16'h0)};
    tbl[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, mk(0, 8'h00, 16'h2000, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 16'h0)};
    tbl[3] = '{1'b1, 1'b0, 16'h0000, 1'b1, mk(0, 8'h00, 16'h2000, 0, 1, 0, 8'h00, 1, 0, 0, 8'h00, 16'h0)};
    tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b1, mk(0, 8'h00, 16'h2000, 0, 0, 1, 8'h00, 1, 0, 0, 8'h00, 16'h0)};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, mk(0, 8'h00, 16'h2000, 0, 0, 0, 8'h02, 1, 0, 0, 8'h00, 16'h0)};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, mk(0, 8'h01, 16'h2000, 0, 0, 0, 8'h00, 0, 0, 0, 8'h01, 16'h1)};

    model_reset();
    @(negedge clk);
    chk(base(), "reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      dp_ok = tbl[i].dp;
      chk(tbl[i].exp, $sformatf("table[%0d]", i));
      drive_step(tbl[i].run, tbl[i].valid, tbl[i].data);
    end
    m_pc = 8'h01; m_cnt = 16'h1; m_instr = 16'h2000; m_err = 1'b0; m_idle = 1'b1;

    // Wait states, then a halt word at address 2.
    run_instr(16'h6001, 3, 1'b1, 1'b1, 1'b0);
    run_instr(16'h0003, 0, 1'b1, 1'b1, 1'b0);

    // Stop at boundary and resume at the new pc.
    do_reset();
    run_instr(16'hA000, 1, 1'b1, 1'b0, 1'b0);
    run_instr(16'hE000, 0, 1'b1, 1'b1, 1'b0);

    // Randomized run long enough to wrap the 8-bit pc.
    for (int k = 0; k < 300; k++) begin
      d = junk();
      if (d[1:0] == 2'b11) d[1:0] = 2'b01;
      run_instr(d, $urandom_range(0, 3), ($urandom_range(0, 7) != 0),
                (k == 299) ? 1'b0 : ($urandom_range(0, 3) != 0), 1'b0);
    end

    // Count saturation from a preloaded near-full value.
    force dut.u_cnt.count_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.u_cnt.count_q;
    m_cnt = 16'hFFFE;
    run_instr(16'h2001, 0, 1'b1, 1'b1, 1'b0);
    run_instr(16'h4002, 0, 1'b1, 1'b1, 1'b0);
    run_instr(16'h8000, 1, 1'b1, 1'b0, 1'b0);

    // Missing dp_done is sticky; reset during EXEC_C clears everything.
    do_reset();
    run_instr(16'h2000, 0, 1'b0, 1'b1, 1'b0);
    run_instr(16'h4000, 0, 1'b1, 1'b1, 1'b0);
    run_instr(16'h6000, 1, 1'b1, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
